core_debug_master: RTL

//  Avalon-MM initiator for the core's debug CSR responder port (s2_*): turns single-beat commands

---
 rtl/dbg_pkg.sv | 44 ++++
 rtl/dbg_csr_xfer.sv | 54 +++++
 rtl/core_debug_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and constants for the core debug master.
//   dbg_op_e    - command opcodes offered by the command bridge
//   dbg_state_e - sequencing states of core_debug_master
//   CSR_*       - byte addresses of the core's debug CSR responder map
//   SNAP_WORDS  - number of pipeline instruction registers in a snapshot
//   snap_addr() - CSR address of snapshot word idx (IF..WB)
package dbg_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_STEP  = 2'd2,
    OP_RSVD  = 2'd3
  } dbg_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_ST_EN,
    S_ST_N,
    S_POLL_RD,
    S_POLL_WAIT,
    S_POLL_GAP,
    S_SNAP_RD,
    S_SNAP_WAIT,
    S_RESP
  } dbg_state_e;

  localparam logic [5:0] CSR_CYCLE_LO = 6'h00;
  localparam logic [5:0] CSR_CYCLE_HI = 6'h04;
  localparam logic [5:0] CSR_STEP_EN  = 6'h08;
  localparam logic [5:0] CSR_STEPS    = 6'h0C;
  localparam logic [5:0] CSR_INSTR_IF = 6'h10;
  localparam logic [5:0] CSR_INSTR_WB = 6'h20;

  localparam int SNAP_WORDS = 5;

  function automatic logic [5:0] snap_addr(input logic [2:0] idx);
    return CSR_INSTR_IF + {1'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/dbg_csr_xfer.sv
// dbg_csr_xfer: single-beat Avalon-MM transfer engine.
//   A one-cycle 'start' (with is_write/addr/wdata) produces one registered
//   m_read or m_write pulse on the next cycle. For reads, 'done' rises the
//   cycle the responder's readdata is valid (one cycle after the m_read
//   pulse) and 'rdata' carries that data during the same cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, is_write, addr,     transfer request from the sequencer
//   wdata
//   m_address, m_read,         Avalon-MM initiator outputs (registered)
//   m_write, m_writedata
//   m_readdata                 responder read data
//   done, rdata                read completion and its data
module dbg_csr_xfer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_write,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [5:0]  m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        done,
  output logic [31:0] rdata
);

  // High during the cycle after an m_read pulse, when readdata is valid.
  logic data_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_address   <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      data_phase  <= 1'b0;
    end else begin
      m_read     <= start & ~is_write;
      m_write    <= start & is_write;
      data_phase <= m_read;
      if (start) begin
        m_address   <= addr;
        m_writedata <= is_write ? wdata : '0;
      end
    end
  end

  assign done  = data_phase;
  assign rdata = data_phase ? m_readdata : '0;

endmodule

// File: rtl/core_debug_master.sv
// core_debug_master: Avalon-MM initiator for the core's debug CSR port.
//   Turns single-beat READ/WRITE commands into CSR transfers and runs the
//   STEP sequence: STEP_EN<=1, STEPS<=N, then poll STEPS every POLL_GAP idle
//   cycles until it reads 0 or POLL_TIMEOUT polls have seen a nonzero value.
// Optional feature: define DBG_TRACE_SNAPSHOT_EN to read the five pipeline
//   instruction registers (IF..WB) after a successful STEP into snap_instr.
//   Without it snap_instr is tied to zero; the port list is unchanged.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/     command channel (accepted in IDLE only)
//   cmd_addr/cmd_wdata
//   rsp_valid/rsp_rdata/rsp_error   one-cycle response per accepted command
//   m_address/m_read/m_readdata/    Avalon-MM initiator to the CSR responder
//   m_write/m_writedata
//   snap_instr                      [0]=IF .. [4]=WB from the last STEP
//   busy                            ~cmd_ready
module core_debug_master
  import dbg_pkg::*;
#(
  parameter int POLL_GAP     = 4,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [5:0]                  cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  output logic                        rsp_valid,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_error,
  output logic [5:0]                  m_address,
  output logic                        m_read,
  input  logic [31:0]                 m_readdata,
  output logic                        m_write,
  output logic [31:0]                 m_writedata,
  output logic [SNAP_WORDS-1:0][31:0] snap_instr,
  output logic                        busy
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;

  dbg_state_e  state;
  logic [5:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [PW-1:0] poll_cnt_reg;

  logic        cmd_bad;
  logic        xfer_start;
  logic        xfer_is_write;
  logic [5:0]  xfer_addr;
  logic [31:0] xfer_wdata;
  logic        xfer_done;
  logic [31:0] xfer_rdata;

`ifdef DBG_TRACE_SNAPSHOT_EN
  logic [2:0]                  snap_idx_reg;
  logic [SNAP_WORDS-1:0][31:0] snap_reg;
`endif

  // Command validation, evaluated on the accept cycle. Misaligned WRITE
  // addresses are covered by the STEP_EN/STEPS-only rule.
  always_comb begin
    cmd_bad = 1'b0;
    case (dbg_op_e'(cmd_op))
      OP_READ:  cmd_bad = (cmd_addr[1:0] != 2'b00) || (cmd_addr > CSR_INSTR_WB);
      OP_WRITE: cmd_bad = (cmd_addr != CSR_STEP_EN) && (cmd_addr != CSR_STEPS);
      OP_STEP:  cmd_bad = 1'b0;
      default:  cmd_bad = 1'b1;
    endcase
  end

  // Issue states last exactly one cycle, so 'start' is a one-cycle pulse.
  always_comb begin
    xfer_start    = 1'b0;
    xfer_is_write = 1'b0;
    xfer_addr     = '0;
    xfer_wdata    = '0;
    case (state)
      S_RD: begin
        xfer_start = 1'b1;
        xfer_addr  = addr_reg;
      end
      S_WR: begin
        xfer_start    = 1'b1;
        xfer_is_write = 1'b1;
        xfer_addr     = addr_reg;
        xfer_wdata    = wdata_reg;
      end
      S_ST_EN: begin
        xfer_start    = 1'b1;
        xfer_is_write = 1'b1;
        xfer_addr     = CSR_STEP_EN;
        xfer_wdata    = 32'd1;
      end
      S_ST_N: begin
        xfer_start    = 1'b1;
        xfer_is_write = 1'b1;
        xfer_addr     = CSR_STEPS;
        xfer_wdata    = wdata_reg;
      end
      S_POLL_RD: begin
        xfer_start = 1'b1;
        xfer_addr  = CSR_STEPS;
      end
`ifdef DBG_TRACE_SNAPSHOT_EN
      S_SNAP_RD: begin
        xfer_start = 1'b1;
        xfer_addr  = snap_addr(snap_idx_reg);
      end
`endif
      default: ;
    endcase
  end

  dbg_csr_xfer u_xfer (
    .clk         (clk),
    .reset       (reset),
    .start       (xfer_start),
    .is_write    (xfer_is_write),
    .addr        (xfer_addr),
    .wdata       (xfer_wdata),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_writedata (m_writedata),
    .m_readdata  (m_readdata),
    .done        (xfer_done),
    .rdata       (xfer_rdata)
  );

  // Sequencer. Every entry into S_RESP loads rsp_valid/rsp_error/rsp_rdata
  // on the same edge so the response is visible for the single RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_rdata    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      gap_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
`ifdef DBG_TRACE_SNAPSHOT_EN
      snap_idx_reg <= '0;
      snap_reg     <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            if (cmd_bad) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              case (dbg_op_e'(cmd_op))
                OP_READ:  state <= S_RD;
                OP_WRITE: state <= S_WR;
                default: begin
                  state        <= S_ST_EN;
                  poll_cnt_reg <= '0;
                end
              endcase
            end
          end
        end
        S_RD:      state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (xfer_done) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= xfer_rdata;
          end
        end
        S_WR: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_error <= 1'b0;
          rsp_rdata <= '0;
        end
        S_ST_EN: begin
          if (wdata_reg == 32'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state <= S_ST_N;
          end
        end
        S_ST_N:    state <= S_POLL_RD;
        S_POLL_RD: state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (xfer_done) begin
            if (xfer_rdata == 32'd0) begin
`ifdef DBG_TRACE_SNAPSHOT_EN
              state        <= S_SNAP_RD;
              snap_idx_reg <= '0;
`else
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b0;
              rsp_rdata <= '0;
`endif
            end else if (poll_cnt_reg == PW'(POLL_TIMEOUT - 1)) begin
              // Timed out: STEP_EN stays set and the old snapshot is kept.
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= xfer_rdata;
            end else begin
              state        <= S_POLL_GAP;
              poll_cnt_reg <= poll_cnt_reg + 1'b1;
              gap_cnt_reg  <= GW'(POLL_GAP - 1);
            end
          end
        end
        S_POLL_GAP: begin
          if (gap_cnt_reg == '0) begin
            state <= S_POLL_RD;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
`ifdef DBG_TRACE_SNAPSHOT_EN
        S_SNAP_RD: state <= S_SNAP_WAIT;
        S_SNAP_WAIT: begin
          if (xfer_done) begin
            snap_reg[snap_idx_reg] <= xfer_rdata;
            if (snap_idx_reg == 3'(SNAP_WORDS - 1)) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state        <= S_SNAP_RD;
              snap_idx_reg <= snap_idx_reg + 1'b1;
            end
          end
        end
`endif
        S_RESP: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_error <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DBG_TRACE_SNAPSHOT_EN
  assign snap_instr = snap_reg;
`else
  assign snap_instr = '0;
`endif

  assign busy = ~cmd_ready;

endmodule
